multicycle_control_unit: RTL and testbench

- Multicycle MIPS controller FSM, the successor to the single-cycle decoder.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several cycles to drive the shared-memory multicycle datapath.
- Adds a memory ready handshake, an optional extended ISA (bne/andi/ori/and/or), illegal-opcode flagging and internal PC-enable generation.

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcode/funct constants and ALU codes for the multicycle controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMMEX    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b011100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // Successor of DECODE; an undecodable opcode returns S_FETCH, which no legal opcode does.
    function automatic state_t decode_next(input logic [5:0] op, input logic ext_isa);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECUTE;
            OP_BEQ:       nxt = S_BRANCH;
            OP_BNE:       nxt = ext_isa ? S_BRANCH : S_FETCH;
            OP_ADDI:      nxt = S_IMMEX;
            OP_ANDI,
            OP_ORI:       nxt = ext_isa ? S_IMMEX : S_FETCH;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps FSM alu_op and funct to a 3-bit ALU operation code
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Unknown R-type funct falls back to add without flagging anything.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_SLT:   alu_control = ALU_SLT;
                    F_MUL:   alu_control = ALU_MUL;
                    F_AND:   alu_control = EXT_ISA ? ALU_AND : ALU_ADD;
                    F_OR:    alu_control = EXT_ISA ? ALU_OR : ALU_ADD;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_IMM: alu_control = (funct == F_OR) ? ALU_OR : ALU_AND;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS controller FSM with memory handshake
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EXT_ISA       = 1'b1,
    parameter int ALUCTRL_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 zero_ext,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_op
);

    state_t     state;
    logic       ready;
    logic       is_bne;
    logic       is_imm_logic;
    logic [1:0] alu_op;
    logic       alu_active;
    logic [5:0] dec_funct;
    logic [2:0] dec_control;

    // Without the handshake every memory access completes in one cycle.
    assign ready        = MEM_HANDSHAKE ? mem_ready : 1'b1;
    // The instruction register is stable after FETCH, so opcode can steer later states.
    assign is_bne       = (opcode == OP_BNE);
    assign is_imm_logic = EXT_ISA && ((opcode == OP_ANDI) || (opcode == OP_ORI));

    // State sequencing; reset aborts any instruction straight back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next(opcode, EXT_ISA);
                S_MEMADR:   state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (ready) state <= S_FETCH;
                S_EXECUTE:  state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_IMMEX:    state <= S_IMMWB;
                S_IMMWB:    state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // ALU operation class per state; IMMWB keeps the IMMEX selection stable.
    always_comb begin
        alu_op     = ALUOP_ADD;
        alu_active = 1'b0;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: alu_active = 1'b1;
            S_EXECUTE: begin
                alu_active = 1'b1;
                alu_op     = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                alu_active = 1'b1;
                alu_op     = ALUOP_SUB;
            end
            S_IMMEX, S_IMMWB: begin
                alu_active = 1'b1;
                alu_op     = is_imm_logic ? ALUOP_IMM : ALUOP_ADD;
            end
            default: ;
        endcase
    end

    // Immediate-logic ops reuse the decoder's and/or selection through a synthetic funct.
    assign dec_funct = (alu_op == ALUOP_IMM) ? ((opcode == OP_ORI) ? F_OR : F_AND) : funct;

    alu_decoder #(
        .EXT_ISA(EXT_ISA)
    ) u_alu_decoder (
        .alu_op     (alu_op),
        .funct      (dec_funct),
        .alu_control(dec_control)
    );

    assign alu_control = (alu_active && rst_n) ? ALUCTRL_W'(dec_control) : '0;

    // Moore decode of datapath controls; memory-gated strobes follow ready, all forced low in reset.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zero_ext   = 1'b0;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_en     = ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = (decode_next(opcode, EXT_ISA) == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_en     = is_bne ? ~zero : zero;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                zero_ext  = is_imm_logic;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                zero_ext  = is_imm_logic;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            zero_ext   = 1'b0;
            pc_src     = 2'b00;
            pc_en      = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, zero_ext, pc_en, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    logic       ne_mem_req, ne_iord, ne_ir_write, ne_mem_write, ne_mem_to_reg, ne_reg_dst, ne_reg_write;
    logic       ne_alu_src_a, ne_zero_ext, ne_pc_en, ne_illegal_op;
    logic [1:0] ne_alu_src_b, ne_pc_src;
    logic [2:0] ne_alu_control;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .ir_write(ir_write),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .zero_ext(zero_ext), .pc_src(pc_src), .pc_en(pc_en),
        .alu_control(alu_control), .illegal_op(illegal_op)
    );

    multicycle_control_unit #(.EXT_ISA(1'b0)) dut_noext (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(ne_mem_req), .iord(ne_iord), .ir_write(ne_ir_write),
        .mem_write(ne_mem_write), .mem_to_reg(ne_mem_to_reg), .reg_dst(ne_reg_dst),
        .reg_write(ne_reg_write), .alu_src_a(ne_alu_src_a), .alu_src_b(ne_alu_src_b),
        .zero_ext(ne_zero_ext), .pc_src(ne_pc_src), .pc_en(ne_pc_en),
        .alu_control(ne_alu_control), .illegal_op(ne_illegal_op)
    );

    logic [17:0] obs, obs_ne;
    assign obs = {mem_req, iord, ir_write, mem_write, mem_to_reg, reg_dst, reg_write,
                  alu_src_a, alu_src_b, zero_ext, pc_src, pc_en, alu_control, illegal_op};
    assign obs_ne = {ne_mem_req, ne_iord, ne_ir_write, ne_mem_write, ne_mem_to_reg, ne_reg_dst,
                     ne_reg_write, ne_alu_src_a, ne_alu_src_b, ne_zero_ext, ne_pc_src, ne_pc_en,
                     ne_alu_control, ne_illegal_op};

    function automatic logic [17:0] o(input logic mr, input logic io, input logic irw,
                                      input logic mw, input logic m2r, input logic rd,
                                      input logic rw, input logic sa, input logic [1:0] sb,
                                      input logic ze, input logic [1:0] ps, input logic pe,
                                      input logic [2:0] alu, input logic il);
        return {mr, io, irw, mw, m2r, rd, rw, sa, sb, ze, ps, pe, alu, il};
    endfunction

    task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Check primary DUT outputs at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check_vec(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_vec("reset_outputs", obs, 18'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [17:0] v_fetch, v_fetch_wait, v_decode, v_dec_ill, v_memadr, v_memread, v_memwb;
    logic [17:0] v_memwrite, v_exec_sub, v_exec_and, v_exec_add, v_aluwb;
    logic [17:0] v_br_taken, v_br_not, v_immex_ori, v_immwb_ori, v_jump;

    initial begin
        v_fetch      = o(1,0,1,0,0,0,0,0,2'b01,0,2'b00,1,3'b010,0);
        v_fetch_wait = o(1,0,0,0,0,0,0,0,2'b01,0,2'b00,0,3'b010,0);
        v_decode     = o(0,0,0,0,0,0,0,0,2'b11,0,2'b00,0,3'b010,0);
        v_dec_ill    = o(0,0,0,0,0,0,0,0,2'b11,0,2'b00,0,3'b010,1);
        v_memadr     = o(0,0,0,0,0,0,0,1,2'b10,0,2'b00,0,3'b010,0);
        v_memread    = o(1,1,0,0,0,0,0,0,2'b00,0,2'b00,0,3'b000,0);
        v_memwb      = o(0,0,0,0,1,0,1,0,2'b00,0,2'b00,0,3'b000,0);
        v_memwrite   = o(1,1,0,1,0,0,0,0,2'b00,0,2'b00,0,3'b000,0);
        v_exec_sub   = o(0,0,0,0,0,0,0,1,2'b00,0,2'b00,0,3'b100,0);
        v_exec_and   = o(0,0,0,0,0,0,0,1,2'b00,0,2'b00,0,3'b000,0);
        v_exec_add   = o(0,0,0,0,0,0,0,1,2'b00,0,2'b00,0,3'b010,0);
        v_aluwb      = o(0,0,0,0,0,1,1,0,2'b00,0,2'b00,0,3'b000,0);
        v_br_taken   = o(0,0,0,0,0,0,0,1,2'b00,0,2'b01,1,3'b100,0);
        v_br_not     = o(0,0,0,0,0,0,0,1,2'b00,0,2'b01,0,3'b100,0);
        v_immex_ori  = o(0,0,0,0,0,0,0,1,2'b10,1,2'b00,0,3'b001,0);
        v_immwb_ori  = o(0,0,0,0,0,0,1,1,2'b10,1,2'b00,0,3'b001,0);
        v_jump       = o(0,0,0,0,0,0,0,0,2'b00,0,2'b10,1,3'b000,0);

        rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // lw with memory always ready: five states, write only in the fifth
        do_reset();
        opcode = 6'b100011;
        step("lw_fetch", v_fetch);
        step("lw_decode", v_decode);
        step("lw_memadr", v_memadr);
        step("lw_memread", v_memread);
        step("lw_memwb", v_memwb);
        step("lw_next_fetch", v_fetch);

        // sw with stalled fetch and a three-cycle stalled write
        do_reset();
        opcode = 6'b101011;
        mem_ready = 1'b0;
        step("sw_fetch_wait0", v_fetch_wait);
        step("sw_fetch_wait1", v_fetch_wait);
        mem_ready = 1'b1;
        step("sw_fetch", v_fetch);
        step("sw_decode", v_decode);
        step("sw_memadr", v_memadr);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("sw_memwrite_wait", v_memwrite);
        mem_ready = 1'b1;
        step("sw_memwrite_done", v_memwrite);
        step("sw_next_fetch", v_fetch);

        // R-type sub
        do_reset();
        opcode = 6'b000000; funct = 6'b100010;
        step("rsub_fetch", v_fetch);
        step("rsub_decode", v_decode);
        step("rsub_execute", v_exec_sub);
        step("rsub_aluwb", v_aluwb);

        // R-type and: extended ISA gives and, base ISA falls back to add
        do_reset();
        funct = 6'b100100;
        step("rand_fetch", v_fetch);
        step("rand_decode", v_decode);
        @(negedge clk);
        check_vec("rand_execute", obs, v_exec_and);
        check_vec("rand_execute_noext", obs_ne, v_exec_add);
        @(posedge clk);
        #1;

        // beq taken
        do_reset();
        opcode = 6'b000100; funct = 6'b0; zero = 1'b1;
        step("beq_fetch", v_fetch);
        step("beq_decode", v_decode);
        step("beq_branch", v_br_taken);
        step("beq_next_fetch", v_fetch);

        // bne with zero=1 is not taken; base ISA flags it as illegal
        do_reset();
        opcode = 6'b000101; zero = 1'b1;
        step("bne_fetch", v_fetch);
        @(negedge clk);
        check_vec("bne_decode", obs, v_decode);
        check_vec("bne_decode_noext", obs_ne, v_dec_ill);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_vec("bne_branch", obs, v_br_not);
        check_vec("bne_noext_back_fetch", obs_ne, v_fetch);
        @(posedge clk);
        #1;

        // ori: zero-extended immediate, or operation held into writeback
        do_reset();
        opcode = 6'b001101; zero = 1'b0;
        step("ori_fetch", v_fetch);
        step("ori_decode", v_decode);
        step("ori_immex", v_immex_ori);
        step("ori_immwb", v_immwb_ori);

        // jump
        do_reset();
        opcode = 6'b000010;
        step("j_fetch", v_fetch);
        step("j_decode", v_decode);
        step("j_jump", v_jump);
        step("j_next_fetch", v_fetch);

        // illegal opcode
        do_reset();
        opcode = 6'b111111;
        step("ill_fetch", v_fetch);
        step("ill_decode", v_dec_ill);
        step("ill_next_fetch", v_fetch);

        // reset during MEMREAD aborts the lw with no writeback
        do_reset();
        opcode = 6'b100011;
        step("abort_fetch", v_fetch);
        step("abort_decode", v_decode);
        step("abort_memadr", v_memadr);
        #2;
        check_vec("abort_memread", obs, v_memread);
        rst_n = 1'b0;
        #1;
        check_vec("abort_immediate", obs, 18'd0);
        @(posedge clk);
        #1;
        check_vec("abort_held", obs, 18'd0);
        rst_n = 1'b1;
        step("abort_refetch", v_fetch);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
